// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
//   Shared definitions for the RAM sequencer/arbiter slice: default RAM
//   geometry, the controller state encoding and the fill-pattern offset.
package ram_ctrl_pkg;

  localparam int DEFAULT_AW          = 10;
  localparam int DEFAULT_DW          = 8;
  localparam int RAM_DEPTH           = 1024;
  localparam int INIT_PATTERN_OFFSET = 1;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. A lone request wins outright; when both
//   requesters ask, the one that was not granted last time wins.
// Ports
//   req        in  2  request bits, bit i = requester i
//   last_grant in  1  index of the requester granted most recently
//   en         in  1  grants are only issued while enabled
//   grant      out 2  one-hot grant, or zero when disabled / no request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  // Grant selection: a conflict goes to the port opposite the last winner,
  // otherwise the request vector is already one-hot (or zero).
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/ram_arb_ctrl.sv
// ram_arb_ctrl
//   Sole driver of a single-port RAM. After reset an optional fill pass
//   writes (addr+1) to every word; afterwards two requesters share the RAM
//   through a round-robin arbiter, one access every two cycles.
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_we/addr/wdata     per-requester command, packed {port1, port0}
//   rsp_valid/rsp_data    one-cycle read response pulse, data held until next
//   init_done             fill pass finished (or skipped), held until reset
//   ram_addr/din/we/sel   registered RAM control pins
//   ram_dout              asynchronous RAM read data
module ram_arb_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int INIT_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            init_done,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  output logic            ram_we,
  output logic            ram_sel,
  input  logic [DW-1:0]   ram_dout
);

  localparam state_e RESET_STATE = (INIT_EN != 0) ? INIT : IDLE;

  state_e state_q, state_d;

  // The fill counter is one bit wider than the address so that its MSB
  // marks the cycle in which the last fill write is on the pins.
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   fill_val;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic          ram_sel_q, ram_sel_d;
  logic          last_grant_q, last_grant_d;
  logic          acc_port_q, acc_port_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          init_done_q, init_done_d;
  logic [1:0]    grant;
  logic          win;
  logic          arb_en;

  assign fill_val = cnt_q + (AW+1)'(INIT_PATTERN_OFFSET);
  assign win      = grant[1];

  // Gating with rst_n keeps req_ready low while reset is held, even in the
  // IDLE reset state of a build without the fill pass.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign ram_sel   = ram_sel_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: INIT leaves once the final fill write has been
  // presented, IDLE moves to ACCESS on any accept, ACCESS always returns.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (cnt_q[AW]) state_d = IDLE;
      IDLE:    if (grant != 2'b00) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic. RAM pins are computed one cycle ahead so they
  // appear registered; sel/we default low so every access lasts one cycle.
  always_comb begin
    cnt_d        = cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = 1'b0;
    ram_sel_d    = 1'b0;
    last_grant_d = last_grant_q;
    acc_port_d   = acc_port_q;
    rsp_valid_d  = 2'b00;
    rsp_data_d   = rsp_data_q;
    init_done_d  = init_done_q;
    unique case (state_q)
      INIT: begin
        if (!cnt_q[AW]) begin
          ram_sel_d  = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = cnt_q[AW-1:0];
          ram_din_d  = fill_val[DW-1:0];
          cnt_d      = cnt_q + (AW+1)'(1);
        end else begin
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        init_done_d = 1'b1;
        if (grant != 2'b00) begin
          ram_sel_d    = 1'b1;
          ram_we_d     = req_we[win];
          ram_addr_d   = win ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
          ram_din_d    = win ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];
          last_grant_d = win;
          acc_port_d   = win;
        end
      end
      ACCESS: begin
        // ram_dout is only trusted here, while a read is on the pins.
        if (ram_sel_q && !ram_we_q) begin
          rsp_data_d              = ram_dout;
          rsp_valid_d[acc_port_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset drops any in-flight response and rewinds
  // the fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      ram_sel_q    <= 1'b0;
      last_grant_q <= 1'b1;
      acc_port_q   <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      init_done_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
      ram_sel_q    <= ram_sel_d;
      last_grant_q <= last_grant_d;
      acc_port_q   <= acc_port_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      init_done_q  <= init_done_d;
    end
  end

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// tb_ram_arb_ctrl
//   Directed bench for ram_arb_ctrl. Two instances share the request inputs:
//   dut_a runs the fill pass, dut_b skips it; each has its own RAM model.
//   Only one instance is out of reset at a time, and use_b selects which
//   instance's outputs are observed.
module tb_ram_arb_ctrl;

  logic        clk;
  logic        rst_n_a, rst_n_b;
  logic        use_b;
  logic [1:0]  req_valid, req_we;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;

  logic [1:0] req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
  logic [7:0] rsp_data_a, rsp_data_b, ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic [9:0] ram_addr_a, ram_addr_b;
  logic       init_done_a, init_done_b, ram_we_a, ram_we_b, ram_sel_a, ram_sel_b;

  logic [1:0] ready_m, rdv_m;
  logic [7:0] rdata_m, din_m;
  logic [9:0] addr_m;
  logic       done_m, we_m, sel_m;

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];

  int errors = 0;
  int checks = 0;

  logic [9:0] addrs [8] = '{10'd3, 10'd17, 10'd100, 10'd511, 10'd512, 10'd700, 10'd1000, 10'd1023};
  logic [7:0] sb [8];

  ram_arb_ctrl #(.AW(10), .DW(8), .INIT_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .init_done(init_done_a),
    .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_we(ram_we_a),
    .ram_sel(ram_sel_a), .ram_dout(ram_dout_a)
  );

  ram_arb_ctrl #(.AW(10), .DW(8), .INIT_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .init_done(init_done_b),
    .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_we(ram_we_b),
    .ram_sel(ram_sel_b), .ram_dout(ram_dout_b)
  );

  // RAM models: synchronous write when selected, asynchronous read.
  always @(posedge clk) begin
    if (ram_sel_a && ram_we_a) mem_a[ram_addr_a] <= ram_din_a;
    if (ram_sel_b && ram_we_b) mem_b[ram_addr_b] <= ram_din_b;
  end
  assign ram_dout_a = mem_a[ram_addr_a];
  assign ram_dout_b = mem_b[ram_addr_b];

  assign ready_m = use_b ? req_ready_b : req_ready_a;
  assign rdv_m   = use_b ? rsp_valid_b : rsp_valid_a;
  assign rdata_m = use_b ? rsp_data_b  : rsp_data_a;
  assign din_m   = use_b ? ram_din_b   : ram_din_a;
  assign addr_m  = use_b ? ram_addr_b  : ram_addr_a;
  assign done_m  = use_b ? init_done_b : init_done_a;
  assign we_m    = use_b ? ram_we_b    : ram_we_a;
  assign sel_m   = use_b ? ram_sel_b   : ram_sel_a;

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case a bounded loop is ever mis-sized.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we,
                               input logic [9:0] a0, input logic [9:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One single-port access from the current sample point: accept in N,
  // pins in N+1, response (reads only) in N+2. Returns at the N+2 sample.
  task automatic access(input int p, input logic we, input logic [9:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp,
                        input bit chk_b2b, input string tag);
    int waits;
    logic [1:0] onehot;
    onehot = (p == 0) ? 2'b01 : 2'b10;
    applyStimulus(onehot, {we, we}, addr, addr, wd, wd);
    #1;
    waits = 0;
    while (ready_m == 2'b00 && waits < 20) begin
      @(negedge clk); #1;
      waits++;
    end
    checkOutput({tag, "_ready"}, 32'(ready_m), 32'(onehot));
    if (chk_b2b) checkOutput({tag, "_b2b"}, waits, 0);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 8'd0, 8'd0);
    #1;
    checkOutput({tag, "_pins"}, {12'd0, sel_m, we_m, addr_m, (we ? din_m : 8'h00)},
                {12'd0, 1'b1, we, addr, (we ? wd : 8'h00)});
    @(negedge clk); #1;
    checkOutput({tag, "_rspv"}, 32'(rdv_m), we ? 32'd0 : 32'(onehot));
    if (!we) checkOutput({tag, "_rspd"}, 32'(rdata_m), 32'(exp));
  endtask

  // Directed sequence covering fill, arbitration, reset and random traffic.
  initial begin
    int k, bad, rdy_bad, accepts, consec, waits, p, w, idx;
    logic [1:0] exp_g, prev_r;
    logic [7:0] d;

    use_b = 1'b0;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 8'd0, 8'd0);
    #1;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    @(negedge clk); @(negedge clk); #1;

    // Reset values of the fill-enabled instance.
    checkOutput("rst_addr", 32'(addr_m), 32'd0);
    checkOutput("rst_din", 32'(din_m), 32'd0);
    checkOutput("rst_we_sel", {30'd0, we_m, sel_m}, 32'd0);
    checkOutput("rst_ready", 32'(ready_m), 32'd0);
    checkOutput("rst_rspv", 32'(rdv_m), 32'd0);
    checkOutput("rst_rspd", 32'(rdata_m), 32'd0);
    checkOutput("rst_done", 32'(done_m), 32'd0);

    // Fill pass with both ports requesting throughout.
    applyStimulus(2'b11, 2'b00, 10'd5, 10'd255, 8'd0, 8'd0);
    rst_n_a = 1'b1;
    k = 0; bad = 0; rdy_bad = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk); #1;
      if (done_m) break;
      if (ready_m != 2'b00) rdy_bad++;
      if (sel_m) begin
        if (!we_m || addr_m != 10'(k) || din_m != 8'(k + 1)) bad++;
        k++;
      end else if (k > 0) begin
        bad++;
      end
    end
    checkOutput("init_done_rise", 32'(done_m), 32'd1);
    checkOutput("init_writes", k, 1024);
    checkOutput("init_pattern", bad, 0);
    checkOutput("init_ready_low", rdy_bad, 0);
    checkOutput("init_end_sel", 32'(sel_m), 32'd0);
    checkOutput("t4_first_accept", 32'(ready_m), 32'h1);

    @(negedge clk);
    applyStimulus(2'b10, 2'b00, 10'd5, 10'd255, 8'd0, 8'd0);
    #1;
    checkOutput("t4_access_ready", 32'(ready_m), 32'd0);
    checkOutput("t4_pins", {20'd0, sel_m, we_m, addr_m}, {20'd0, 1'b1, 1'b0, 10'd5});
    @(negedge clk); #1;
    checkOutput("t1_rd5_rspv", 32'(rdv_m), 32'h1);
    checkOutput("t1_rd5_rspd", 32'(rdata_m), 32'h06);
    checkOutput("t4_overlap_accept", 32'(ready_m), 32'h2);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 8'd0, 8'd0);
    #1;
    checkOutput("t1_rd255_addr", 32'(addr_m), 32'd255);
    @(negedge clk); #1;
    checkOutput("t1_rd255_rspv", 32'(rdv_m), 32'h2);
    checkOutput("t1_rd255_rspd", 32'(rdata_m), 32'h00);
    access(0, 1'b0, 10'd0, 8'd0, 8'h01, 1'b1, "t1_rd0");
    access(0, 1'b0, 10'd1023, 8'd0, 8'h00, 1'b1, "t1_rd1023");

    // Write by port 0 then read back by port 1.
    access(0, 1'b1, 10'd10, 8'hA5, 8'h00, 1'b1, "t2_wr");
    access(1, 1'b0, 10'd10, 8'h00, 8'hA5, 1'b1, "t2_rd");

    // Both ports held valid: alternating grants, never in adjacent cycles.
    applyStimulus(2'b11, 2'b00, 10'd5, 10'd10, 8'd0, 8'd0);
    #1;
    exp_g = 2'b01; accepts = 0; consec = 0; prev_r = 2'b00;
    for (int c = 0; c < 40; c++) begin
      if (ready_m != 2'b00) begin
        checkOutput("t3_rr_grant", 32'(ready_m), 32'(exp_g));
        exp_g = ~exp_g;
        accepts++;
        if (prev_r != 2'b00) consec++;
      end
      prev_r = ready_m;
      if (accepts == 8) break;
      @(negedge clk); #1;
    end
    checkOutput("t3_accepts", accepts, 8);
    checkOutput("t3_no_consecutive", consec, 0);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 8'd0, 8'd0);
    @(negedge clk); @(negedge clk); #1;

    // Reset in the ACCESS cycle of a read.
    applyStimulus(2'b01, 2'b00, 10'd10, 10'd0, 8'd0, 8'd0);
    #1;
    waits = 0;
    while (ready_m == 2'b00 && waits < 20) begin
      @(negedge clk); #1;
      waits++;
    end
    checkOutput("t5_accept", 32'(ready_m), 32'h1);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 8'd0, 8'd0);
    #1;
    checkOutput("t5_in_access", 32'(sel_m), 32'd1);
    rst_n_a = 1'b0;
    #1;
    checkOutput("t5_sel_drop", 32'(sel_m), 32'd0);
    checkOutput("t5_addr_rst", 32'(addr_m), 32'd0);
    checkOutput("t5_done_rst", 32'(done_m), 32'd0);
    @(negedge clk); #1;
    checkOutput("t5_no_rsp", 32'(rdv_m), 32'd0);
    rst_n_a = 1'b1;
    waits = 0;
    while (!sel_m && waits < 6) begin
      @(negedge clk); #1;
      waits++;
    end
    checkOutput("t5_restart0", {14'd0, sel_m, we_m, addr_m, din_m}, {14'd0, 1'b1, 1'b1, 10'd0, 8'h01});
    @(negedge clk); #1;
    checkOutput("t5_restart1", {14'd0, sel_m, we_m, addr_m, din_m}, {14'd0, 1'b1, 1'b1, 10'd1, 8'h02});
    rst_n_a = 1'b0;

    // Instance without fill pass: reset gating, init_done rise, traffic.
    use_b = 1'b1;
    applyStimulus(2'b11, 2'b00, 10'd0, 10'd0, 8'd0, 8'd0);
    #1;
    checkOutput("b_rst_ready", 32'(ready_m), 32'd0);
    checkOutput("b_rst_sel", 32'(sel_m), 32'd0);
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 8'd0, 8'd0);
    @(negedge clk);
    rst_n_b = 1'b1;
    #1;
    checkOutput("b_done_low", 32'(done_m), 32'd0);
    @(negedge clk); #1;
    checkOutput("b_done_high", 32'(done_m), 32'd1);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      access(i % 2, 1'b1, addrs[i], d, 8'h00, 1'b1, "t6_seed");
      sb[i] = d;
    end
    for (int i = 0; i < 20; i++) begin
      p   = int'($urandom_range(0, 1));
      w   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 7));
      d   = 8'($urandom);
      access(p, w[0], addrs[idx], d, sb[idx], 1'b1, "t6_op");
      if (w != 0) sb[idx] = d;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
